// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC alarm block: register map,
// CTRL/STAT bit positions, BCD limits and BCD helper functions.
package rtc_pkg;

    typedef enum logic [2:0] {
        REG_SEC   = 3'd0,
        REG_MIN   = 3'd1,
        REG_HOUR  = 3'd2,
        REG_ASEC  = 3'd3,
        REG_AMIN  = 3'd4,
        REG_AHOUR = 3'd5,
        REG_CTRL  = 3'd6,
        REG_STAT  = 3'd7
    } reg_e;

    localparam int CTRL_RUN = 0;
    localparam int CTRL_AEN = 1;
    localparam int CTRL_IEN = 2;

    localparam int STAT_AF = 0;
    localparam int STAT_TF = 1;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

    // Low digit 0-9 plus v <= max also bounds the high digit,
    // since packed BCD orders the same as plain binary.
    function automatic logic bcd_ok(
        input logic [7:0] v,
        input logic [7:0] max
    );
        return (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    function automatic logic [7:0] bcd_inc(
        input logic [7:0] v,
        input logic [7:0] max
    );
        if (v == max)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'h0};
        return v + 8'd1;
    endfunction

endpackage

// File: rtl/rtc_bcd_field.sv
// One packed-BCD time digit pair (0..MAX_BCD) with load and increment.
// Ports: clk_i, rst_n_i, inc_i, load_i, load_dat_i -> dat_o, carry_o.
module rtc_bcd_field
    import rtc_pkg::*;
#(
    parameter logic [7:0] MAX_BCD = 8'h59
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       inc_i,
    input  logic       load_i,
    input  logic [7:0] load_dat_i,
    output logic [7:0] dat_o,
    output logic       carry_o
);

    // Carry fires on the increment that wraps MAX_BCD -> 00.
    assign carry_o = inc_i && (dat_o == MAX_BCD);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dat_o <= 8'h00;
        end else if (load_i) begin
            dat_o <= load_dat_i;
        end else if (inc_i) begin
            dat_o <= bcd_inc(dat_o, MAX_BCD);
        end
    end

endmodule

// File: rtl/rtc_alarm.sv
// Real-time clock (HH:MM:SS, packed BCD) with alarm and Wishbone slave.
// Ports: clk_i, rst_n_i, Wishbone cyc/stb/we/sel/adr/dat_i -> dat_o, ack_o; irq_o.
module rtc_alarm
    import rtc_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000,
    parameter int PRESCALE_W = 27
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        irq_o
);

    localparam logic [PRESCALE_W-1:0] PS_LAST =
        PRESCALE_W'(CLOCK_FREQ - 1);

    logic [PRESCALE_W-1:0] presc;
    logic [7:0] sec, min, hour;
    logic [7:0] asec, amin, ahour;
    logic [7:0] nsec, nmin, nhour;
    logic [2:0] ctrl;
    logic       af, tf;
    logic       idle_seen;
    logic       sec_c, min_c, hour_c;
    logic [7:0] rdata;
    logic [1:0] w1c;
    reg_e       ra;
    logic       acc, wr;
    logic [7:0] wd;
    logic       wr_sec, wr_min, wr_hour, time_wr;
    logic       run, tick, af_set;
    logic       unused;

    assign unused = ^{adr_i[31:5], adr_i[1:0],
                      sel_i[3:1], dat_i[31:8], hour_c};

    assign ra = reg_e'(adr_i[4:2]);
    assign wd = dat_i[7:0];

    // An access that was in flight across reset is never acked:
    // the bus must go idle once before a new access is accepted.
    assign acc = cyc_i & stb_i & ~ack_o & idle_seen;
    assign wr  = acc & we_i & sel_i[0];

    assign wr_sec  = wr && (ra == REG_SEC)  && bcd_ok(wd, SEC_MAX);
    assign wr_min  = wr && (ra == REG_MIN)  && bcd_ok(wd, MIN_MAX);
    assign wr_hour = wr && (ra == REG_HOUR) && bcd_ok(wd, HOUR_MAX);
    assign time_wr = wr_sec | wr_min | wr_hour;

    // A time write restarts the second and swallows a coincident tick.
    assign run  = ctrl[CTRL_RUN];
    assign tick = run && (presc == PS_LAST) && !time_wr;

    assign w1c = (wr && ra == REG_STAT) ? wd[1:0] : 2'b00;

    rtc_bcd_field #(.MAX_BCD(SEC_MAX)) u_sec (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .inc_i      (tick),
        .load_i     (wr_sec),
        .load_dat_i (wd),
        .dat_o      (sec),
        .carry_o    (sec_c)
    );

    rtc_bcd_field #(.MAX_BCD(MIN_MAX)) u_min (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .inc_i      (sec_c),
        .load_i     (wr_min),
        .load_dat_i (wd),
        .dat_o      (min),
        .carry_o    (min_c)
    );

    rtc_bcd_field #(.MAX_BCD(HOUR_MAX)) u_hour (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .inc_i      (min_c),
        .load_i     (wr_hour),
        .load_dat_i (wd),
        .dat_o      (hour),
        .carry_o    (hour_c)
    );

    // Alarm compares against the time as it will be after this edge.
    assign nsec  = tick  ? bcd_inc(sec,  SEC_MAX)  : sec;
    assign nmin  = sec_c ? bcd_inc(min,  MIN_MAX)  : min;
    assign nhour = min_c ? bcd_inc(hour, HOUR_MAX) : hour;

    assign af_set = tick && ctrl[CTRL_AEN] &&
                    ({nhour, nmin, nsec} == {ahour, amin, asec});

    always_comb begin
        rdata = 8'h00;
        unique case (ra)
            REG_SEC:   rdata = sec;
            REG_MIN:   rdata = min;
            REG_HOUR:  rdata = hour;
            REG_ASEC:  rdata = asec;
            REG_AMIN:  rdata = amin;
            REG_AHOUR: rdata = ahour;
            REG_CTRL:  rdata = {5'b0, ctrl};
            REG_STAT:  rdata = {6'b0, tf, af};
            default:   rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            presc     <= '0;
            asec      <= 8'h00;
            amin      <= 8'h00;
            ahour     <= 8'h00;
            ctrl      <= 3'b000;
            af        <= 1'b0;
            tf        <= 1'b0;
            ack_o     <= 1'b0;
            dat_o     <= 32'h0;
            irq_o     <= 1'b0;
            idle_seen <= 1'b0;
        end else begin
            idle_seen <= idle_seen | ~(cyc_i & stb_i);
            ack_o     <= acc;
            if (acc)
                dat_o <= {24'h0, rdata};

            if (time_wr)
                presc <= '0;
            else if (run)
                presc <= (presc == PS_LAST) ? '0 : presc + PRESCALE_W'(1);

            if (wr && ra == REG_ASEC && bcd_ok(wd, SEC_MAX))
                asec <= wd;
            if (wr && ra == REG_AMIN && bcd_ok(wd, MIN_MAX))
                amin <= wd;
            if (wr && ra == REG_AHOUR && bcd_ok(wd, HOUR_MAX))
                ahour <= wd;
            if (wr && ra == REG_CTRL)
                ctrl <= wd[2:0];

            // Set wins over a simultaneous write-1-to-clear.
            af    <= af_set | (af & ~w1c[STAT_AF]);
            tf    <= tick   | (tf & ~w1c[STAT_TF]);
            irq_o <= af & ctrl[CTRL_IEN];
        end
    end

endmodule

// File: tb/tb_rtc_alarm.sv
// Directed self-checking bench for rtc_alarm with CLOCK_FREQ=10.
// Covers reset, BCD validation, rollover, alarm/irq, collisions, reset.
module tb_rtc_alarm;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        cyc_i, stb_i, we_i;
    logic [3:0]  sel_i;
    logic [31:0] adr_i, dat_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        irq_o;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    localparam logic [2:0] A_SEC   = 3'd0;
    localparam logic [2:0] A_MIN   = 3'd1;
    localparam logic [2:0] A_HOUR  = 3'd2;
    localparam logic [2:0] A_ASEC  = 3'd3;
    localparam logic [2:0] A_AMIN  = 3'd4;
    localparam logic [2:0] A_AHOUR = 3'd5;
    localparam logic [2:0] A_CTRL  = 3'd6;
    localparam logic [2:0] A_STAT  = 3'd7;

    always #5 clk_i = ~clk_i;

    rtc_alarm #(.CLOCK_FREQ(10), .PRESCALE_W(4)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .cyc_i   (cyc_i),
        .stb_i   (stb_i),
        .we_i    (we_i),
        .sel_i   (sel_i),
        .adr_i   (adr_i),
        .dat_i   (dat_i),
        .dat_o   (dat_o),
        .ack_o   (ack_o),
        .irq_o   (irq_o)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives at a falling edge; returns 1.5 cycles after the
    // rising edge on which the access takes effect.
    task automatic wb_cycle(input logic w,
                            input logic [2:0] r,
                            input logic [7:0] d,
                            input logic [3:0] s,
                            output logic [31:0] q);
        int n;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = w;
        sel_i = s;
        adr_i = {27'h5A5A5A5, r, 2'b01};
        dat_i = {24'hC3C3C3, d};
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!ack_o && n < 8);
        check("ack_rise", {31'b0, ack_o}, 32'd1);
        q = dat_o;
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
        @(negedge clk_i);
        check("ack_pulse", {31'b0, ack_o}, 32'd0);
    endtask

    task automatic wb_write(input logic [2:0] r, input logic [7:0] d);
        logic [31:0] q;
        wb_cycle(1'b1, r, d, 4'b0001, q);
    endtask

    task automatic rd_chk(input string tag,
                          input logic [2:0] r,
                          input logic [31:0] exp);
        logic [31:0] q;
        wb_cycle(1'b0, r, 8'h00, 4'b1111, q);
        check(tag, q, exp);
    endtask

    initial begin
        logic [31:0] q;
        rst_n_i = 1'b0;
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
        sel_i = 4'b0;
        adr_i = 32'h0;
        dat_i = 32'h0;

        // Reset state and read-back of every register.
        repeat (3) @(negedge clk_i);
        check("rst_dat", dat_o, 32'h0);
        check("rst_ack", {31'b0, ack_o}, 32'h0);
        check("rst_irq", {31'b0, irq_o}, 32'h0);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        for (int i = 0; i < 8; i++)
            rd_chk("rst_reg", 3'(i), 32'h0);

        // Invalid BCD / out of range writes and sel gating.
        wb_write(A_SEC, 8'h34);
        rd_chk("sec_ok", A_SEC, 32'h34);
        wb_write(A_SEC, 8'h5A);
        rd_chk("sec_5a", A_SEC, 32'h34);
        wb_write(A_SEC, 8'h60);
        rd_chk("sec_60", A_SEC, 32'h34);
        wb_write(A_HOUR, 8'h24);
        rd_chk("hour_24", A_HOUR, 32'h0);
        wb_cycle(1'b1, A_SEC, 8'h11, 4'b1110, q);
        rd_chk("sel0_off", A_SEC, 32'h34);
        wb_write(A_CTRL, 8'hF8);
        rd_chk("ctrl_rsv", A_CTRL, 32'h0);

        // Rollover 23:59:58 -> 00:00:00 after 20 clocks.
        wb_write(A_HOUR, 8'h23);
        wb_write(A_MIN,  8'h59);
        wb_write(A_SEC,  8'h58);
        wb_write(A_CTRL, 8'h01);
        repeat (18) @(negedge clk_i);
        wb_write(A_CTRL, 8'h00);
        rd_chk("roll_sec",  A_SEC,  32'h00);
        rd_chk("roll_min",  A_MIN,  32'h00);
        rd_chk("roll_hour", A_HOUR, 32'h00);
        rd_chk("roll_stat", A_STAT, 32'h02);
        wb_write(A_STAT, 8'h02);
        rd_chk("tf_clr", A_STAT, 32'h00);

        // Alarm at 00:00:02 with irq one clock after AF.
        wb_write(A_ASEC,  8'h02);
        wb_write(A_AMIN,  8'h00);
        wb_write(A_AHOUR, 8'h00);
        rd_chk("asec_rb", A_ASEC, 32'h02);
        wb_write(A_SEC,  8'h00);
        wb_write(A_MIN,  8'h00);
        wb_write(A_HOUR, 8'h00);
        wb_write(A_CTRL, 8'h07);
        repeat (19) @(negedge clk_i);
        check("irq_pre", {31'b0, irq_o}, 32'd0);
        @(negedge clk_i);
        check("irq_set", {31'b0, irq_o}, 32'd1);
        wb_write(A_CTRL, 8'h06);
        rd_chk("al_stat", A_STAT, 32'h03);
        rd_chk("al_sec", A_SEC, 32'h02);
        wb_write(A_STAT, 8'h01);
        check("irq_clr", {31'b0, irq_o}, 32'd0);
        rd_chk("af_clr", A_STAT, 32'h02);
        wb_write(A_STAT, 8'h03);

        // SEC write on the wrap edge: tick moves 10 clocks later.
        wb_write(A_SEC, 8'h00);
        wb_write(A_CTRL, 8'h01);
        repeat (8) @(negedge clk_i);
        wb_write(A_SEC, 8'h30);
        repeat (7) @(negedge clk_i);
        wb_write(A_CTRL, 8'h00);
        rd_chk("col_sec", A_SEC, 32'h30);
        wb_write(A_CTRL, 8'h01);
        wb_write(A_CTRL, 8'h00);
        rd_chk("col_next", A_SEC, 32'h31);

        // Reset in the middle of an acked read while running.
        wb_write(A_CTRL, 8'h01);
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = 1'b0;
        adr_i = {27'h0, A_CTRL, 2'b00};
        @(negedge clk_i);
        check("mid_ack", {31'b0, ack_o}, 32'd1);
        check("mid_dat", dat_o, 32'h1);
        rst_n_i = 1'b0;
        #1;
        check("ar_ack", {31'b0, ack_o}, 32'd0);
        check("ar_dat", dat_o, 32'h0);
        check("ar_irq", {31'b0, irq_o}, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("no_late_ack", {31'b0, ack_o}, 32'd0);
        end
        cyc_i = 1'b0;
        stb_i = 1'b0;
        repeat (25) @(negedge clk_i);
        rd_chk("post_sec", A_SEC, 32'h00);
        rd_chk("post_ctrl", A_CTRL, 32'h00);
        wb_write(A_CTRL, 8'h01);
        repeat (9) @(negedge clk_i);
        wb_write(A_CTRL, 8'h00);
        rd_chk("resume", A_SEC, 32'h01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
